// File: rtl/ser_load_en_gen.sv
// ---------------------------------------------------------------------------
// ser_load_en_gen
//
// Upstream driver for a downstream single-bit enable flop (d_in/en_in pair).
// A parallel frame is accepted through a valid/ready handshake and shifted out
// MSB-first on d_out. en_out strobes once per bit, every DIV clocks, and
// done_out pulses for one cycle once the last bit has been strobed.
//
// Optional feature macro: SER_ABORT_EN
//   When defined, the abort_in port exists and cancels a frame in flight.
//   When undefined, a frame always runs to completion or to reset.
//
// Parameters
//   WIDTH  bits per frame (>= 2)
//   DIV    clocks per bit (>= 1)
//
// Ports
//   clk          in   clock, all state updates on posedge
//   reset_al_in  in   asynchronous active-low reset
//   load_in      in   frame valid
//   data_in      in   [WIDTH-1:0] frame, captured on accept
//   abort_in     in   cancel the frame in flight (SER_ABORT_EN only)
//   ready_out    out  idle, a frame can be accepted
//   d_out        out  serial data bit
//   en_out       out  one-cycle bit strobe
//   busy_out     out  frame in progress
//   done_out     out  one-cycle pulse after the last bit
// ---------------------------------------------------------------------------
module ser_load_en_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset_al_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] data_in,
`ifdef SER_ABORT_EN
    input  logic             abort_in,
`endif
    output logic             ready_out,
    output logic             d_out,
    output logic             en_out,
    output logic             busy_out,
    output logic             done_out
);

    // DIV=1 would give a zero-width counter; keep one bit that stays at 0.
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW = $clog2(WIDTH);

    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [DCW-1:0]     div_cnt_q;
    logic [BCW-1:0]     bit_cnt_q;
    logic               done_q;

    logic               strobe;
    logic               abort;

`ifdef SER_ABORT_EN
    assign abort = abort_in;
`else
    assign abort = 1'b0;
`endif

    // Strobe is decoded purely from registers, so en_out has no path from
    // any input and cannot glitch on input activity.
    assign strobe = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // ready_out is high throughout IDLE, so load_in alone is
                    // the accept condition; abort_in is ignored here.
                    if (load_in) begin
                        shreg_q   <= data_in;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        // Bits already strobed stay in the downstream flop;
                        // nothing further is emitted, and no done pulse.
                        state_q   <= IDLE;
                        shreg_q   <= '0;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end else if (div_cnt_q != DIV_LAST) begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end else begin
                        div_cnt_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            // Last strobe: frame complete. Clearing shreg keeps
                            // d_out at 0 while idle.
                            state_q   <= IDLE;
                            done_q    <= 1'b1;
                            shreg_q   <= '0;
                            bit_cnt_q <= '0;
                        end else begin
                            shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_out = (state_q == IDLE);
    assign busy_out  = (state_q == SHIFT);
    assign en_out    = strobe;
    assign d_out     = (state_q == SHIFT) && shreg_q[WIDTH-1];
    assign done_out  = done_q;

endmodule
